// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   DEPTH-entry FIFO of {pc, instruction} pairs sitting between fetch (IF)
//   and decode (ID). Fetch pushes with a valid/ready handshake, decode pops
//   the head with id_ready. When empty, decode sees a NOP bubble (NOP_INSTR,
//   pc 0). A synchronous flush discards every entry on a branch/jump redirect.
//
//   Optional build macro: IF_ID_STATS_EN adds the saturating performance
//   counters stall_cycles and flush_count.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   flush          synchronous discard of all entries (highest priority)
//   if_valid       fetch presents pc/instruction
//   if_ready       queue accepts an entry (not full); depends only on state
//   pc             fetch pc
//   instruction    fetched instruction
//   id_ready       decode consumes the head this cycle
//   id_valid       head entry valid (queue not empty)
//   id_pc          head pc, 0 when empty
//   id_instruction head instruction, NOP_INSTR when empty
//   count          current occupancy
//   stall_cycles   (IF_ID_STATS_EN) cycles with id_valid & !id_ready
//   flush_count    (IF_ID_STATS_EN) cycles flushing a non-empty queue
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int                       WORD_BITWIDTH = 32,
  parameter int                       DEPTH         = 2,
  parameter logic [WORD_BITWIDTH-1:0] NOP_INSTR     = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [WORD_BITWIDTH-1:0]     pc,
  input  logic [WORD_BITWIDTH-1:0]     instruction,
  input  logic                         id_ready,
  output logic                         id_valid,
  output logic [WORD_BITWIDTH-1:0]     id_pc,
  output logic [WORD_BITWIDTH-1:0]     id_instruction,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IF_ID_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  flush_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Saturating increment for the 32-bit statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [WORD_BITWIDTH-1:0] pc_mem    [DEPTH];
  logic [WORD_BITWIDTH-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             push;
  logic             pop;

  // Handshake flags come only from registered state: no IF->ID or
  // ID->IF combinational paths. A full queue refuses a push even if the
  // head is popped in the same cycle.
  assign if_ready = (cnt_q != FULL_CNT);
  assign id_valid = (cnt_q != '0);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;
  assign count    = cnt_q;

  // Head is read straight out of storage; the empty mux makes the reset
  // values appear as soon as rst clears the count, without a clock edge.
  assign id_pc          = id_valid ? pc_mem[rd_ptr]    : '0;
  assign id_instruction = id_valid ? instr_mem[rd_ptr] : NOP_INSTR;

  // Storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= instruction;
    end
  end

  // Control: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef IF_ID_STATS_EN
  // Statistics survive flush; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (id_valid && !id_ready) stall_cycles <= sat_inc(stall_cycles);
      if (flush && id_valid)     flush_count  <= sat_inc(flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   pc;
  logic [31:0]   instruction;
  logic          id_ready;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_instruction;
  logic [CW-1:0] count;
`ifdef IF_ID_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   flush_count;
`endif

  if_id_queue #(.WORD_BITWIDTH(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .pc(pc),
    .instruction(instruction),
    .id_ready(id_ready),
    .id_valid(id_valid),
    .id_pc(id_pc),
    .id_instruction(id_instruction),
    .count(count)
`ifdef IF_ID_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of {pc, instruction}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, "/valid"}, 32'(id_valid), 32'(q.size() != 0));
    check({tag, "/ready"}, 32'(if_ready), 32'(q.size() != DEPTH));
    check({tag, "/count"}, 32'(count), 32'(q.size()));
    check({tag, "/pc"},    id_pc,          (q.size() != 0) ? q[0].pc  : 32'h0);
    check({tag, "/instr"}, id_instruction, (q.size() != 0) ? q[0].ins : NOP);
`ifdef IF_ID_STATS_EN
    check({tag, "/stall"}, stall_cycles, m_stall);
    check({tag, "/flushc"}, flush_count, m_flush);
`endif
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic cycle(input string tag, input logic v, input logic [31:0] p,
                       input logic [31:0] ins, input logic rdy, input logic fl);
    bit do_push;
    bit do_pop;
    if_valid    = v;
    pc          = p;
    instruction = ins;
    id_ready    = rdy;
    flush       = fl;
    @(posedge clk);
    do_push = v && (q.size() < DEPTH);
    do_pop  = rdy && (q.size() > 0);
    if (q.size() > 0 && !rdy) m_stall = sat(m_stall);
    if (fl && q.size() > 0)   m_flush = sat(m_flush);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{pc: p, ins: ins});
    end
    #1;
    check_all(tag);
  endtask

  // Assert rst between edges and check outputs before any clock edge.
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    q.delete();
    m_stall = '0;
    m_flush = '0;
    #1 check_all(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    pc = '0; instruction = '0;
    m_stall = '0; m_flush = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_all("reset");
    check("reset_nop", id_instruction, 32'h00000013);
    check("reset_rdy", 32'(if_ready), 32'd1);

    // Single push, popped the following edge.
    cycle("push1", 1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0);
    check("push1_pc", id_pc, 32'h100);
    cycle("pop1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("pop1_cnt", 32'(count), 32'd0);

    // Fill while stalled; third push refused.
    cycle("fill0", 1'b1, 32'h100, 32'hA0, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 32'h104, 32'hA4, 1'b0, 1'b0);
    check("full_rdy", 32'(if_ready), 32'd0);
    cycle("fill2", 1'b1, 32'h108, 32'hA8, 1'b0, 1'b0);
    check("full_cnt", 32'(count), 32'd2);
    check("full_head", id_pc, 32'h100);
    cycle("drain0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drain0_pc", id_pc, 32'h104);
    cycle("drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Push and pop together at count=1.
    cycle("pp0", 1'b1, 32'h200, 32'hB0, 1'b0, 1'b0);
    cycle("pp1", 1'b1, 32'h204, 32'hB4, 1'b1, 1'b0);
    check("pp_pc", id_pc, 32'h204);
    check("pp_cnt", 32'(count), 32'd1);
    cycle("pp2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush a two-entry queue while a push is offered.
    cycle("fl0", 1'b1, 32'h2F0, 32'hC0, 1'b0, 1'b0);
    cycle("fl1", 1'b1, 32'h2F4, 32'hC4, 1'b0, 1'b0);
    cycle("fl2", 1'b1, 32'h300, 32'hC8, 1'b0, 1'b1);
    check("fl_nop", id_instruction, NOP);
    cycle("fl3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle("fl4", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Three stalled cycles on a one-entry queue.
    cycle("st0", 1'b1, 32'h400, 32'hD0, 1'b0, 1'b0);
    repeat (3) cycle("st", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle("st4", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Continuous streaming: pointers wrap several times.
    p = 32'h500;
    for (int i = 0; i < 3*DEPTH + 1; i++) begin
      cycle("stream", 1'b1, p, p ^ 32'h5A5A_0000, 1'b1, 1'b0);
      p = p + 32'd4;
    end

    // Random mix of push, stall and occasional flush.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset with a full queue.
    cycle("pre_rst0", 1'b1, 32'h600, 32'hE0, 1'b0, 1'b0);
    cycle("pre_rst1", 1'b1, 32'h604, 32'hE4, 1'b0, 1'b0);
    async_reset("arst");
    check("arst_nop", id_instruction, NOP);
    cycle("post_rst0", 1'b1, 32'h700, 32'hF0, 1'b0, 1'b0);
    cycle("post_rst1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of {pc, instruction} pairs between fetch and decode.
- Valid/ready handshakes replace the single stall input; adds a synchronous flush for branch/jump redirect.
- Decode sees a NOP bubble whenever the queue is empty.
- Lets fetch run ahead of short decode stalls without losing instructions.

Parameters:
- WORD_BITWIDTH, 32, width of pc and instruction.
- DEPTH, 2, number of entries; power of two, >= 2.
- NOP_INSTR, 32'h00000013, instruction presented to ID when empty (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all entries (branch taken / redirect).
- if_valid  input  1  fetch presents a valid pc/instruction.
- if_ready  output  1  queue accepts an entry this cycle.
- pc  input  WORD_BITWIDTH  fetch pc.
- instruction  input  WORD_BITWIDTH  fetched instruction.
- id_ready  input  1  decode consumes the head this cycle (0 = hazard stall).
- id_valid  output  1  head entry valid.
- id_pc  output  WORD_BITWIDTH  head pc.
- id_instruction  output  WORD_BITWIDTH  head instruction, or NOP_INSTR when empty.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset, async on rst high:
  - wr_ptr = rd_ptr = count = 0; id_valid = 0; id_pc = 0; id_instruction = NOP_INSTR.
  - Storage contents are don't-care.
  - if_ready = 1 immediately after rst deasserts.
- Push = if_valid & if_ready. Pop = id_valid & id_ready.
- if_ready = (count != DEPTH). Purely a function of state; no combinational path from id_ready. A full queue does not accept, even when a pop occurs in the same cycle.
- id_valid = (count != 0). id_pc and id_instruction come directly from the storage entry at rd_ptr (muxed with NOP_INSTR and 0 when empty). No combinational path from if_* inputs.
- Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle), including when the queue was empty. There is no same-cycle bypass.
- Ordering: strict FIFO. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push only: write entry at wr_ptr; wr_ptr++; count++.
- Pop only: rd_ptr++; count--.
- Push and pop in the same cycle (only possible when 0 < count < DEPTH): both pointers advance; count unchanged.
- Pop while empty is ignored, since id_valid=0. Push while full is impossible, since if_ready=0. No counter overflow or underflow is possible.
- Flush, synchronous, highest priority:
  - On the edge, pointers and count go to 0.
  - Any push or pop in the same cycle is discarded.
  - id_valid = 0 and id_instruction = NOP_INSTR from the next cycle.
  - if_ready is not gated by flush; a push offered during flush is dropped.
- Flush held multiple cycles keeps the queue empty.
- rst asserted mid-operation discards all entries immediately, asynchronously.
- Stall without flush (id_ready=0): head and all entries hold; fetch may fill the remaining slots, then if_ready drops.

Optional Feature:
- Macro IF_ID_STATS_EN.
- Defined: adds outputs stall_cycles [31:0] and flush_count [31:0].
  - stall_cycles increments each cycle id_valid & !id_ready.
  - flush_count increments each cycle flush is high and count != 0.
  - Both reset to 0 on rst and saturate at 32'hFFFFFFFF. Neither is cleared by flush.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Required: id_valid=0, id_instruction=32'h00000013, id_pc=0, if_ready=1, count=0.
- Push pc=0x100 / instr=0x00500093 with id_ready=1:
  - Required: one cycle later id_valid=1, id_pc=0x100, id_instruction=0x00500093.
  - Required: popped the following edge; count returns to 0.
- DEPTH=2, id_ready=0, push 0x100, 0x104, 0x108 on consecutive cycles:
  - Required: count=2 and if_ready=0 after two pushes; 0x108 is not accepted.
  - Then id_ready=1: heads 0x100 then 0x104, in order.
- Simultaneous push and pop at count=1 (head 0x200, push 0x204):
  - Required: count stays 1, head becomes 0x204.
- Queue holds 2 entries; flush=1 together with if_valid (pc 0x300):
  - Required: next cycle count=0, id_valid=0, id_instruction=NOP; 0x300 is not stored.
- Continuous push/pop for 3*DEPTH entries, then rst pulse mid-stream:
  - Required before reset: pointer wrap preserves order.
  - Required on rst: outputs return to reset values without waiting for a clock edge.
  - With IF_ID_STATS_EN: 3 stalled cycles give stall_cycles=3; flushing a non-empty queue increments flush_count by 1.
